// File: rtl/hood_mode_scheduler_if.sv
// Button-pulse / status bundle between the hood front panel logic and the
// mode scheduler. The scheduler connects through the slave modport.
interface hood_mode_scheduler_if #(
  parameter int unsigned TIME_WIDTH = 16
) ();
  logic                  power_on;
  logic                  menu_pulse;
  logic                  req_first;
  logic                  req_second;
  logic                  req_third;
  logic                  req_clean;
  logic [2:0]            mode;
  logic [1:0]            fan_level;
  logic [TIME_WIDTH-1:0] remaining;
  logic                  third_used;
  logic                  clean_done;

  modport master (
    output power_on, menu_pulse, req_first, req_second, req_third, req_clean,
    input  mode, fan_level, remaining, third_used, clean_done
  );

  modport slave (
    input  power_on, menu_pulse, req_first, req_second, req_third, req_clean,
    output mode, fan_level, remaining, third_used, clean_done
  );
endinterface

// File: rtl/hood_mode_scheduler.sv
// Central mode controller for the kitchen exhaust hood: owns the operating
// mode, the one-second prescaler and the timed countdowns (hurricane, menu
// exit, self-clean). All outputs are registered.
// Optional feature: define THIRD_ONCE_EN to allow hurricane mode only once
// per power cycle.
module hood_mode_scheduler #(
  parameter int unsigned TICK_DIV   = 100_000_000,
  parameter int unsigned THIRD_TIME = 60,
  parameter int unsigned CLEAN_TIME = 180,
  parameter int unsigned TIME_WIDTH = 16
) (
  input logic                  clk,
  input logic                  rst,
  hood_mode_scheduler_if.slave bus
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]         TickLast  = PW'(TICK_DIV - 1);
  localparam logic [TIME_WIDTH-1:0] ThirdLoad = TIME_WIDTH'(THIRD_TIME);
  localparam logic [TIME_WIDTH-1:0] CleanLoad = TIME_WIDTH'(CLEAN_TIME);
  localparam logic [TIME_WIDTH-1:0] TimeOne   = TIME_WIDTH'(1);

  typedef enum logic [2:0] {
    StOff       = 3'd0,
    StStandby   = 3'd1,
    StFirst     = 3'd2,
    StSecond    = 3'd3,
    StThird     = 3'd4,
    StThirdExit = 3'd5,
    StClean     = 3'd6
  } state_e;

  state_e                state_q, state_d;
  logic [TIME_WIDTH-1:0] rem_q, rem_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [1:0]            fan_q, fan_d;
  logic                  used_q, used_d;
  logic                  done_q, done_d;
  logic                  timed;
  logic                  tick;
  logic                  last_sec;
  logic                  third_ok;

`ifdef THIRD_ONCE_EN
  assign third_ok = ~used_q;
`else
  assign third_ok = 1'b1;
`endif

  // Tick strobe: only meaningful while a countdown is running.
  always_comb begin
    timed    = (state_q == StThird) || (state_q == StThirdExit) || (state_q == StClean);
    tick     = timed && (presc_q == TickLast);
    last_sec = (rem_q <= TimeOne);
  end

  // Next-state decode; priority is power, menu, third, second, first, clean.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    used_d  = used_q;
    done_d  = 1'b0;
    if (!bus.power_on) begin
      state_d = StOff;
      rem_d   = '0;
      used_d  = 1'b0;
    end else begin
      unique case (state_q)
        StOff: state_d = StStandby;
        StStandby: begin
          if (bus.req_third && third_ok) begin
            state_d = StThird;
            rem_d   = ThirdLoad;
            used_d  = 1'b1;
          end else if (bus.req_second) begin
            state_d = StSecond;
          end else if (bus.req_first) begin
            state_d = StFirst;
          end else if (bus.req_clean) begin
            state_d = StClean;
            rem_d   = CleanLoad;
          end
        end
        StFirst, StSecond: begin
          if (bus.menu_pulse) begin
            state_d = StStandby;
          end else if (bus.req_third && third_ok) begin
            state_d = StThird;
            rem_d   = ThirdLoad;
            used_d  = 1'b1;
          end else if (bus.req_second && state_q == StFirst) begin
            state_d = StSecond;
          end else if (bus.req_first && state_q == StSecond) begin
            state_d = StFirst;
          end
        end
        StThird: begin
          // Menu wins over a coincident expiry tick.
          if (bus.menu_pulse) begin
            state_d = StThirdExit;
            rem_d   = ThirdLoad;
          end else if (tick) begin
            if (last_sec) begin
              state_d = StSecond;
              rem_d   = '0;
            end else begin
              rem_d = rem_q - TimeOne;
            end
          end
        end
        StThirdExit: begin
          if (tick) begin
            if (last_sec) begin
              state_d = StStandby;
              rem_d   = '0;
            end else begin
              rem_d = rem_q - TimeOne;
            end
          end
        end
        StClean: begin
          if (bus.menu_pulse) begin
            state_d = StStandby;
            rem_d   = '0;
          end else if (tick) begin
            if (last_sec) begin
              state_d = StStandby;
              rem_d   = '0;
              done_d  = 1'b1;
            end else begin
              rem_d = rem_q - TimeOne;
            end
          end
        end
        default: begin
          state_d = StOff;
          rem_d   = '0;
        end
      endcase
    end
  end

  // Prescaler restarts on any state change so each timed state starts a fresh second.
  always_comb begin
    presc_d = '0;
    if (timed && (state_d == state_q) && !tick) begin
      presc_d = presc_q + PW'(1);
    end
  end

  // Fan level follows the state being entered.
  always_comb begin
    fan_d = 2'd0;
    unique case (state_d)
      StFirst, StClean:     fan_d = 2'd1;
      StSecond:             fan_d = 2'd2;
      StThird, StThirdExit: fan_d = 2'd3;
      default:              fan_d = 2'd0;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StOff;
      rem_q   <= '0;
      presc_q <= '0;
      fan_q   <= 2'd0;
      used_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      presc_q <= presc_d;
      fan_q   <= fan_d;
      used_q  <= used_d;
      done_q  <= done_d;
    end
  end

  assign bus.mode       = state_q;
  assign bus.fan_level  = fan_q;
  assign bus.remaining  = rem_q;
  assign bus.third_used = used_q;
  assign bus.clean_done = done_q;

endmodule

// File: tb/tb_hood_mode_scheduler.sv
// Scoreboard bench for hood_mode_scheduler with TICK_DIV=4, THIRD_TIME=3,
// CLEAN_TIME=5. Expected outputs are queued as each stimulus step is driven
// and popped when the step's last clock edge has passed.
module tb_hood_mode_scheduler;

  typedef struct packed {
    logic [2:0]  mode;
    logic [1:0]  fan;
    logic [15:0] rem;
    logic        used;
    logic        done;
  } obs_t;

  typedef struct {
    int         n;
    logic       pwr;
    logic [4:0] pls;
    string      name;
    obs_t       exp;
  } step_t;

  typedef struct {
    string name;
    obs_t  v;
  } exp_t;

  // Pulse bit order: {menu, third, second, first, clean}.
  localparam logic [4:0] PNone   = 5'b00000;
  localparam logic [4:0] PMenu   = 5'b10000;
  localparam logic [4:0] PThird  = 5'b01000;
  localparam logic [4:0] PSecond = 5'b00100;
  localparam logic [4:0] PFirst  = 5'b00010;
  localparam logic [4:0] PClean  = 5'b00001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  hood_mode_scheduler_if #(.TIME_WIDTH(16)) bus ();

  hood_mode_scheduler #(
    .TICK_DIV  (4),
    .THIRD_TIME(3),
    .CLEAN_TIME(5),
    .TIME_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic obs_t mk(input int m, input int f, input int r, input bit u, input bit d);
    obs_t o;
    o.mode = 3'(m);
    o.fan  = 2'(f);
    o.rem  = 16'(r);
    o.used = u;
    o.done = d;
    return o;
  endfunction

  function automatic step_t mkstep(input int n, input logic pwr, input logic [4:0] pls,
                                   input string name, input obs_t exp);
    step_t s;
    s.n    = n;
    s.pwr  = pwr;
    s.pls  = pls;
    s.name = name;
    s.exp  = exp;
    return s;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.mode = bus.mode;
    o.fan  = bus.fan_level;
    o.rem  = bus.remaining;
    o.used = bus.third_used;
    o.done = bus.clean_done;
    return o;
  endfunction

  // Pulses are held for the first edge of the step only; the expectation
  // applies after the step's last edge.
  task automatic drive_step(input step_t s);
    exp_t e;
    bus.power_on = s.pwr;
    {bus.menu_pulse, bus.req_third, bus.req_second, bus.req_first, bus.req_clean} = s.pls;
    e.name = s.name;
    e.v    = s.exp;
    sb.push_back(e);
    cyc(1);
    {bus.menu_pulse, bus.req_third, bus.req_second, bus.req_first, bus.req_clean} = PNone;
    if (s.n > 1) cyc(s.n - 1);
  endtask

  task automatic test_reset();
    exp_t e;
    obs_t got;
    rst = 1'b1;
    bus.power_on = 1'b0;
    {bus.menu_pulse, bus.req_third, bus.req_second, bus.req_first, bus.req_clean} = PNone;
    e.name = "reset_off";
    e.v    = mk(0, 0, 0, 0, 0);
    sb.push_back(e);
    cyc(2);
    e = sb.pop_front();
    got = sample();
    checks++;
    if (got !== e.v) begin
      errors++;
      $display("FAIL %s: got mode=%0d fan=%0d rem=%0d used=%0b done=%0b, want mode=%0d fan=%0d rem=%0d used=%0b done=%0b",
               e.name, got.mode, got.fan, got.rem, got.used, got.done,
               e.v.mode, e.v.fan, e.v.rem, e.v.used, e.v.done);
    end
    rst = 1'b0;
    drive_step(mkstep(1, 1'b1, PNone, "reset_power_on", mk(1, 0, 0, 0, 0)));
    e = sb.pop_front();
    got = sample();
    checks++;
    if (got !== e.v) begin
      errors++;
      $display("FAIL %s: got mode=%0d fan=%0d rem=%0d used=%0b done=%0b, want mode=%0d fan=%0d rem=%0d used=%0b done=%0b",
               e.name, got.mode, got.fan, got.rem, got.used, got.done,
               e.v.mode, e.v.fan, e.v.rem, e.v.used, e.v.done);
    end
  endtask

  task automatic test_levels();
    step_t q[$];
    exp_t  e;
    obs_t  got;
    q.push_back(mkstep(1, 1'b1, PFirst,  "lvl_first",       mk(2, 1, 0, 0, 0)));
    q.push_back(mkstep(1, 1'b1, PSecond, "lvl_second",      mk(3, 2, 0, 0, 0)));
    q.push_back(mkstep(1, 1'b1, PSecond, "lvl_second_noop", mk(3, 2, 0, 0, 0)));
    q.push_back(mkstep(1, 1'b1, PClean,  "lvl_clean_ign",   mk(3, 2, 0, 0, 0)));
    q.push_back(mkstep(1, 1'b1, PMenu,   "lvl_menu",        mk(1, 0, 0, 0, 0)));
    q.push_back(mkstep(1, 1'b1, PMenu,   "lvl_menu_ign",    mk(1, 0, 0, 0, 0)));
    while (q.size() > 0) begin
      drive_step(q.pop_front());
      e = sb.pop_front();
      got = sample();
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL %s: got mode=%0d fan=%0d rem=%0d used=%0b done=%0b, want mode=%0d fan=%0d rem=%0d used=%0b done=%0b",
                 e.name, got.mode, got.fan, got.rem, got.used, got.done,
                 e.v.mode, e.v.fan, e.v.rem, e.v.used, e.v.done);
      end
    end
  endtask

  task automatic test_third_countdown();
    step_t q[$];
    exp_t  e;
    obs_t  got;
    q.push_back(mkstep(1, 1'b1, PThird, "third_entry", mk(4, 3, 3, 1, 0)));
    q.push_back(mkstep(3, 1'b1, PNone,  "third_c3",    mk(4, 3, 3, 1, 0)));
    q.push_back(mkstep(1, 1'b1, PNone,  "third_c4",    mk(4, 3, 2, 1, 0)));
    q.push_back(mkstep(4, 1'b1, PNone,  "third_c8",    mk(4, 3, 1, 1, 0)));
    q.push_back(mkstep(3, 1'b1, PNone,  "third_c11",   mk(4, 3, 1, 1, 0)));
    q.push_back(mkstep(1, 1'b1, PNone,  "third_c12",   mk(3, 2, 0, 1, 0)));
    while (q.size() > 0) begin
      drive_step(q.pop_front());
      e = sb.pop_front();
      got = sample();
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL %s: got mode=%0d fan=%0d rem=%0d used=%0b done=%0b, want mode=%0d fan=%0d rem=%0d used=%0b done=%0b",
                 e.name, got.mode, got.fan, got.rem, got.used, got.done,
                 e.v.mode, e.v.fan, e.v.rem, e.v.used, e.v.done);
      end
    end
  endtask

  task automatic test_third_once();
    step_t q[$];
    exp_t  e;
    obs_t  got;
`ifdef THIRD_ONCE_EN
    q.push_back(mkstep(1, 1'b1, PThird, "once_blocked",  mk(3, 2, 0, 1, 0)));
`else
    q.push_back(mkstep(1, 1'b1, PThird, "once_reenter",  mk(4, 3, 3, 1, 0)));
`endif
    q.push_back(mkstep(1, 1'b0, PNone,  "once_pwr_off",  mk(0, 0, 0, 0, 0)));
    q.push_back(mkstep(1, 1'b1, PNone,  "once_pwr_on",   mk(1, 0, 0, 0, 0)));
    q.push_back(mkstep(1, 1'b1, PThird, "once_again",    mk(4, 3, 3, 1, 0)));
    while (q.size() > 0) begin
      drive_step(q.pop_front());
      e = sb.pop_front();
      got = sample();
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL %s: got mode=%0d fan=%0d rem=%0d used=%0b done=%0b, want mode=%0d fan=%0d rem=%0d used=%0b done=%0b",
                 e.name, got.mode, got.fan, got.rem, got.used, got.done,
                 e.v.mode, e.v.fan, e.v.rem, e.v.used, e.v.done);
      end
    end
  endtask

  // Continues from a freshly entered THIRD (remaining=3).
  task automatic test_third_exit();
    step_t q[$];
    exp_t  e;
    obs_t  got;
    q.push_back(mkstep(4, 1'b1, PNone,   "exit_pre_rem2", mk(4, 3, 2, 1, 0)));
    q.push_back(mkstep(1, 1'b1, PMenu,   "exit_entry",    mk(5, 3, 3, 1, 0)));
    q.push_back(mkstep(1, 1'b1, PSecond, "exit_req2_ign", mk(5, 3, 3, 1, 0)));
    q.push_back(mkstep(3, 1'b1, PMenu,   "exit_c4",       mk(5, 3, 2, 1, 0)));
    q.push_back(mkstep(7, 1'b1, PNone,   "exit_c11",      mk(5, 3, 1, 1, 0)));
    q.push_back(mkstep(1, 1'b1, PNone,   "exit_c12",      mk(1, 0, 0, 1, 0)));
    while (q.size() > 0) begin
      drive_step(q.pop_front());
      e = sb.pop_front();
      got = sample();
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL %s: got mode=%0d fan=%0d rem=%0d used=%0b done=%0b, want mode=%0d fan=%0d rem=%0d used=%0b done=%0b",
                 e.name, got.mode, got.fan, got.rem, got.used, got.done,
                 e.v.mode, e.v.fan, e.v.rem, e.v.used, e.v.done);
      end
    end
  endtask

  task automatic test_clean();
    step_t q[$];
    exp_t  e;
    obs_t  got;
    q.push_back(mkstep(1,  1'b1, PClean, "clean_entry",     mk(6, 1, 5, 1, 0)));
    q.push_back(mkstep(19, 1'b1, PNone,  "clean_c19",       mk(6, 1, 1, 1, 0)));
    q.push_back(mkstep(1,  1'b1, PNone,  "clean_done",      mk(1, 0, 0, 1, 1)));
    q.push_back(mkstep(1,  1'b1, PNone,  "clean_done_gone", mk(1, 0, 0, 1, 0)));
    q.push_back(mkstep(1,  1'b1, PClean, "clean2_entry",    mk(6, 1, 5, 1, 0)));
    q.push_back(mkstep(12, 1'b1, PNone,  "clean2_rem2",     mk(6, 1, 2, 1, 0)));
    q.push_back(mkstep(1,  1'b1, PMenu,  "clean2_abort",    mk(1, 0, 0, 1, 0)));
    q.push_back(mkstep(1,  1'b1, PNone,  "clean2_no_done",  mk(1, 0, 0, 1, 0)));
    q.push_back(mkstep(1,  1'b1, PClean, "clean3_entry",    mk(6, 1, 5, 1, 0)));
    q.push_back(mkstep(19, 1'b1, PNone,  "clean3_c19",      mk(6, 1, 1, 1, 0)));
    q.push_back(mkstep(1,  1'b1, PMenu,  "clean3_menu_exp", mk(1, 0, 0, 1, 0)));
    q.push_back(mkstep(1,  1'b1, PNone,  "clean3_no_done",  mk(1, 0, 0, 1, 0)));
    while (q.size() > 0) begin
      drive_step(q.pop_front());
      e = sb.pop_front();
      got = sample();
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL %s: got mode=%0d fan=%0d rem=%0d used=%0b done=%0b, want mode=%0d fan=%0d rem=%0d used=%0b done=%0b",
                 e.name, got.mode, got.fan, got.rem, got.used, got.done,
                 e.v.mode, e.v.fan, e.v.rem, e.v.used, e.v.done);
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t q[$];
    exp_t  e;
    obs_t  got;
    q.push_back(mkstep(1,  1'b0, PNone,                   "b2b_off",        mk(0, 0, 0, 0, 0)));
    q.push_back(mkstep(1,  1'b1, PNone,                   "b2b_on",         mk(1, 0, 0, 0, 0)));
    q.push_back(mkstep(1,  1'b1, PThird | PFirst,         "b2b_third_wins", mk(4, 3, 3, 1, 0)));
    q.push_back(mkstep(1,  1'b0, PNone,                   "b2b_off2",       mk(0, 0, 0, 0, 0)));
    q.push_back(mkstep(1,  1'b1, PNone,                   "b2b_on2",        mk(1, 0, 0, 0, 0)));
    q.push_back(mkstep(1,  1'b1, PSecond | PFirst | PClean, "b2b_sec_wins", mk(3, 2, 0, 0, 0)));
    q.push_back(mkstep(1,  1'b1, PMenu,                   "b2b_standby",    mk(1, 0, 0, 0, 0)));
    q.push_back(mkstep(1,  1'b1, PClean,                  "b2b_clean",      mk(6, 1, 5, 0, 0)));
    q.push_back(mkstep(19, 1'b1, PNone,                   "b2b_clean_c19",  mk(6, 1, 1, 0, 0)));
    q.push_back(mkstep(1,  1'b0, PNone,                   "b2b_pwr_cut",    mk(0, 0, 0, 0, 0)));
    q.push_back(mkstep(1,  1'b0, PClean,                  "b2b_off_hold",   mk(0, 0, 0, 0, 0)));
    while (q.size() > 0) begin
      drive_step(q.pop_front());
      e = sb.pop_front();
      got = sample();
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL %s: got mode=%0d fan=%0d rem=%0d used=%0b done=%0b, want mode=%0d fan=%0d rem=%0d used=%0b done=%0b",
                 e.name, got.mode, got.fan, got.rem, got.used, got.done,
                 e.v.mode, e.v.fan, e.v.rem, e.v.used, e.v.done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_levels();
    test_third_countdown();
    test_third_once();
    test_third_exit();
    test_clean();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hood_mode_scheduler.md
# hood_mode_scheduler

- Central mode controller for the kitchen exhaust hood.
- Inputs: the debounced, single-cycle button pulses.
- Owns the current operating mode and the one-second prescaler.
- Runs the timed modes: the hurricane (third) countdown, the menu-exit countdown and the self-clean countdown.
- Drives fan level and remaining-time outputs to the display and fan-driver blocks.

## Interface
Parameters:
- TICK_DIV, 100_000_000: clock cycles per one-second tick.
- THIRD_TIME, 60: third-mode duration in seconds; also the menu-exit countdown length.
- CLEAN_TIME, 180: self-clean duration in seconds.
- TIME_WIDTH, 16: width of the remaining-time output.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- power_on  in  1  level; 0 forces the OFF state.
- menu_pulse  in  1  one-cycle menu button pulse.
- req_first, req_second, req_third, req_clean  in  1 each  one-cycle mode request pulses.
- mode  out  3  OFF=0, STANDBY=1, FIRST=2, SECOND=3, THIRD=4, THIRD_EXIT=5, CLEAN=6.
- fan_level  out  2  0 in OFF/STANDBY, 1 in FIRST/CLEAN, 2 in SECOND, 3 in THIRD/THIRD_EXIT.
- remaining  out  TIME_WIDTH  seconds left in THIRD/THIRD_EXIT/CLEAN; 0 in every other state.
- third_used  out  1  third mode already entered since power-on.
- clean_done  out  1  one-cycle pulse when self-clean completes naturally.

## Operation
- All outputs are registered.
- Reset values: mode=OFF, fan_level=0, remaining=0, third_used=0, clean_done=0, prescaler=0.
- Priority within a cycle: power_on=0 first, then menu_pulse, then req_third, req_second, req_first, req_clean.
  - Only the highest-priority pulse valid in the current state acts; all others are dropped.
  - Pulses are never queued.
- OFF:
  - Stays in OFF while power_on=0; third_used is cleared.
  - power_on=1 moves to STANDBY.
- STANDBY:
  - req_first, req_second and req_clean go to FIRST, SECOND and CLEAN.
  - req_third goes to THIRD when permitted.
  - menu_pulse is ignored.
- FIRST/SECOND:
  - menu_pulse returns to STANDBY.
  - req_first/req_second switch between the two levels; a request for the current level is a no-op.
  - req_third goes to THIRD when permitted.
  - req_clean is ignored.
- THIRD:
  - On entry: remaining=THIRD_TIME, third_used=1.
  - remaining decrements on each tick; the tick that makes it 0 moves to SECOND instead (remaining shows 0 after it).
  - menu_pulse moves to THIRD_EXIT with remaining reloaded to THIRD_TIME.
  - All other requests are ignored.
- THIRD_EXIT:
  - Fan stays at level 3 and the countdown runs as in THIRD.
  - Expiry goes to STANDBY.
  - All requests and menu_pulse are ignored.
- CLEAN:
  - On entry: remaining=CLEAN_TIME; it counts down per tick.
  - Expiry goes to STANDBY and asserts clean_done for exactly one cycle, coincident with mode=STANDBY.
  - menu_pulse aborts to STANDBY with no clean_done.
  - Other requests are ignored.
- power_on=0 in any state goes to OFF next cycle, clears remaining and the prescaler, and suppresses clean_done.

## Timing
- A request or menu pulse sampled at edge k gives new mode/fan_level/remaining valid after edge k, i.e. 1-cycle latency.
- Prescaler:
  - Counts 0..TICK_DIV-1 while in a timed state.
  - Clears on every state change and in untimed states.
  - The tick fires on the cycle the prescaler equals TICK_DIV-1.
  - So the first decrement occurs TICK_DIV cycles after entry.
- A timed state lasts exactly N*TICK_DIV cycles, where N is the loaded time.
- remaining never underflows and never wraps; reload happens only on state entry.
- A menu_pulse on the same cycle as an expiry tick takes priority:
  - THIRD goes to THIRD_EXIT.
  - CLEAN goes to STANDBY without clean_done.

## Configuration
- THIRD_ONCE_EN defined:
  - req_third is permitted only while third_used=0, so third mode can be entered once per power cycle.
  - Later req_third pulses are ignored.
- THIRD_ONCE_EN undefined:
  - req_third is always permitted from STANDBY/FIRST/SECOND.
  - third_used still sets and clears as specified but does not gate entry.

## Test plan
All scenarios use TICK_DIV=4, THIRD_TIME=3, CLEAN_TIME=5.
- rst=1 for 2 cycles, then power_on=1 -> mode=OFF under reset; mode=STANDBY 1 cycle after power_on sampled; remaining=0, fan_level=0.
- From STANDBY, req_third -> mode=4, remaining=3, third_used=1; remaining 2, 1, 0 at cycles 4, 8, 12 after entry; at the 12th cycle mode=SECOND and fan_level=2.
- In THIRD at remaining=2, menu_pulse -> mode=5, remaining=3; STANDBY exactly 12 cycles later; req_second during THIRD_EXIT has no effect.
- With THIRD_ONCE_EN, a second req_third after the first hurricane cycle -> mode stays SECOND. After power_on 1->0->1, req_third -> THIRD again. Without the macro, the second req_third enters THIRD.
- req_clean from STANDBY -> mode=6, fan_level=1; after 20 cycles mode=STANDBY with a single-cycle clean_done. A repeat run with menu_pulse at remaining=2 -> STANDBY, clean_done stays 0.
- Same-cycle req_first+req_third in STANDBY -> THIRD. power_on=0 mid-CLEAN -> OFF next cycle, remaining=0, no clean_done.
